implication_responder: RTL and testbench
========================================

IMPLICATION_RESPONDER -- requirements
Module: implication_responder

Interface
REQ-001 The block SHALL have parameter IMPLICATION_KIND, default OVERLAPPING, selecting the minimum antecedent-to-consequent latency (OVERLAPPING = 0, NON_OVERLAPPING = 1).
REQ-002 The block SHALL have parameter MAX_DELAY, default 7, legal range 1..15, giving the maximum latency in cycles.
REQ-003 clk  input  1  single clock; all state changes on posedge clk.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 enable  input  1  when 0, antecedent is ignored; pending responses still drain.
REQ-006 antecedent  input  1  request pulse; one request per high cycle.
REQ-007 delay  input  4  requested latency, sampled in the same cycle as antecedent.
REQ-008 inject_fail  input  1  when high with an accepted request, that request's consequent is suppressed.
REQ-009 flush  input  1  synchronous clear of all pending responses.
REQ-010 consequent  output  1  response pulse.
REQ-011 outstanding  output  4  number of pending scheduled responses.
REQ-012 req_count  output  16  accepted requests, saturating.
REQ-013 ack_count  output  16  consequent pulses issued, saturating.
REQ-014 collision_count  output  8  merged responses, saturating.

Function
REQ-015 A request SHALL be accepted in cycle t when antecedent=1, enable=1 and flush=0.
REQ-016 The effective delay SHALL be delay clamped to MAX_DELAY, then raised to 1 when IMPLICATION_KIND=NON_OVERLAPPING and delay=0.
REQ-017 An accepted request with effective delay d and inject_fail=0 SHALL drive consequent high in exactly cycle t+d.
REQ-018 Effective delay 0 SHALL drive consequent combinationally in cycle t, with no register on the antecedent-to-consequent path.
REQ-019 Pending responses SHALL be held in a schedule vector sched_q[MAX_DELAY-1:0], where bit i means "due i cycles from now" and bit 0 drives consequent.
REQ-020 Each cycle, sched_q[i] SHALL load sched_q[i+1] OR (accepted AND effective delay = i+1); the top bit loads only the new request.
REQ-021 A request landing on an already-set slot (including slot 0 for delay 0) SHALL produce one consequent pulse only, and collision_count SHALL increment by 1.
REQ-022 inject_fail SHALL still increment req_count for the request, but SHALL NOT set any schedule bit and SHALL NOT count a collision.
REQ-023 flush=1 SHALL clear sched_q at the next edge, force consequent=0 in the same cycle, and cause antecedent to be ignored in that cycle.
REQ-024 outstanding SHALL equal the population count of registered sched_q, excluding any delay-0 request in flight in the current cycle.
REQ-025 req_count SHALL increment by 1 per accepted request, and ack_count SHALL increment by 1 per cycle with consequent=1.
REQ-026 All counters SHALL hold at all-ones on saturation and never wrap.
REQ-027 enable falling with responses pending SHALL NOT cancel them.

Reset
REQ-028 rst_n low SHALL asynchronously clear sched_q and all counters.
REQ-029 During reset, consequent and outstanding SHALL be 0, and antecedent SHALL be ignored.
REQ-030 Reset asserted mid-operation SHALL discard pending responses, with no consequent after release for requests made before reset.

Structure
REQ-031 Enum implication_kind_e (OVERLAPPING, NON_OVERLAPPING) and the counter width constants SHALL live in a shared package, implication_pkg.
REQ-032 The saturating counter SHALL be one sub-module, sat_counter, parameterised by width and instantiated three times.

Verification
REQ-033 OVERLAPPING, antecedent=1 with delay=0 at cycle 5 -> consequent=1 in cycle 5; req_count=1, ack_count=1.
REQ-034 NON_OVERLAPPING, antecedent with delay=0 at cycle 5 -> consequent only in cycle 6; delay=3 at cycle 10 -> consequent in cycle 13.
REQ-035 delay=4 at cycle 0 and delay=2 at cycle 2 -> single consequent in cycle 4; collision_count=1, ack_count=1, req_count=2.
REQ-036 delay=12 with MAX_DELAY=7 at cycle 0 -> consequent in cycle 7; outstanding=1 in cycles 1..7, then 0.
REQ-037 Requests with delays 5 and 6 at cycles 0 and 1, then flush at cycle 2 -> no consequent through cycle 10; outstanding=0 from cycle 3.
REQ-038 inject_fail with delay=2 at cycle 0 -> no consequent at cycle 2; req_count=1, ack_count=0; rst_n low at cycle 3 with 2 pending -> all outputs 0 and no later consequent.

Source files
------------

// File: rtl/implication_pkg.sv
// Shared types, widths and the effective-delay rule for the implication responder.
package implication_pkg;

    typedef enum logic {
        OVERLAPPING     = 1'b0,
        NON_OVERLAPPING = 1'b1
    } implication_kind_e;

    localparam int DELAY_W   = 4;
    localparam int OUTST_W   = 4;
    localparam int REQ_CNT_W = 16;
    localparam int ACK_CNT_W = 16;
    localparam int COL_CNT_W = 8;

    // Clamp to the schedule depth first; a non-overlapping zero delay then becomes one cycle.
    function automatic logic [DELAY_W-1:0] effective_delay(
        input logic [DELAY_W-1:0] delay,
        input int                 max_delay,
        input implication_kind_e  kind
    );
        logic [DELAY_W-1:0] d;
        d = (int'(delay) > max_delay) ? DELAY_W'(max_delay) : delay;
        if (kind == NON_OVERLAPPING && delay == '0) begin
            d = DELAY_W'(1);
        end
        return d;
    endfunction

endpackage

// File: rtl/implication_responder_if.sv
// Request/response bus of the implication responder; the responder takes the slave side.
interface implication_responder_if;
    import implication_pkg::*;

    logic                 enable;
    logic                 antecedent;
    logic [DELAY_W-1:0]   delay;
    logic                 inject_fail;
    logic                 flush;
    logic                 consequent;
    logic [OUTST_W-1:0]   outstanding;
    logic [REQ_CNT_W-1:0] req_count;
    logic [ACK_CNT_W-1:0] ack_count;
    logic [COL_CNT_W-1:0] collision_count;

    modport master (
        output enable, antecedent, delay, inject_fail, flush,
        input  consequent, outstanding, req_count, ack_count, collision_count
    );

    modport slave (
        input  enable, antecedent, delay, inject_fail, flush,
        output consequent, outstanding, req_count, ack_count, collision_count
    );

endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (inc && count_reg != '1) begin
            count_reg <= count_reg + WIDTH'(1);
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/implication_responder.sv
// Schedules one consequent pulse per accepted antecedent after a programmable latency,
// merging requests that land on the same cycle and counting requests, pulses and merges.
module implication_responder
    import implication_pkg::*;
#(
    parameter implication_kind_e IMPLICATION_KIND = OVERLAPPING,
    parameter int                MAX_DELAY        = 7
) (
    input  logic                    clk,
    input  logic                    rst_n,
    implication_responder_if.slave  bus
);

    logic [MAX_DELAY-1:0] sched_q;
    logic [MAX_DELAY-1:0] sched_next;
    logic [MAX_DELAY:0]   sched_ext;
    logic [MAX_DELAY:0]   slot_hit;
    logic [DELAY_W-1:0]   eff_delay;
    logic                 accepted;
    logic                 hit;
    logic                 collision;
    logic                 consequent;
    logic [OUTST_W-1:0]   pop;

    // rst_n gates acceptance so nothing is scheduled or fired while reset is held.
    assign accepted  = rst_n & bus.enable & bus.antecedent & ~bus.flush;
    assign hit       = accepted & ~bus.inject_fail;
    assign eff_delay = effective_delay(bus.delay, MAX_DELAY, IMPLICATION_KIND);
    assign sched_ext = {1'b0, sched_q};

    // slot_hit[i]: the new request is due i cycles from now; slot 0 is the same-cycle path.
    genvar gi;
    generate
        for (gi = 0; gi <= MAX_DELAY; gi++) begin : g_slot
            assign slot_hit[gi] = hit && (eff_delay == DELAY_W'(gi));
        end
        for (gi = 0; gi < MAX_DELAY; gi++) begin : g_sched
            assign sched_next[gi] = ~bus.flush & (sched_ext[gi+1] | slot_hit[gi+1]);
        end
    endgenerate

    // A request whose target slot is already occupied merges into the existing pulse.
    assign collision  = |(slot_hit & sched_ext);
    assign consequent = ~bus.flush & (sched_q[0] | slot_hit[0]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sched_q <= '0;
        end else begin
            sched_q <= sched_next;
        end
    end

    always_comb begin
        pop = '0;
        for (int i = 0; i < MAX_DELAY; i++) begin
            pop = pop + OUTST_W'(sched_q[i]);
        end
    end

    sat_counter #(.WIDTH(REQ_CNT_W)) u_req_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (accepted),
        .count (bus.req_count)
    );

    sat_counter #(.WIDTH(ACK_CNT_W)) u_ack_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (consequent),
        .count (bus.ack_count)
    );

    sat_counter #(.WIDTH(COL_CNT_W)) u_col_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (collision),
        .count (bus.collision_count)
    );

    assign bus.consequent  = consequent;
    assign bus.outstanding = pop;

endmodule

// File: tb/tb_implication_responder.sv
// Drives an OVERLAPPING and a NON_OVERLAPPING responder with identical stimulus and checks
// both against a scoreboard of expected fire cycles.
module tb_implication_responder;
    import implication_pkg::*;

    localparam int MAXD = 7;

    typedef struct {
        int kind;
        int issue;
        int fire;
    } ent_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    implication_responder_if if_a ();
    implication_responder_if if_b ();

    implication_responder #(.IMPLICATION_KIND(OVERLAPPING), .MAX_DELAY(MAXD)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_a.slave)
    );

    implication_responder #(.IMPLICATION_KIND(NON_OVERLAPPING), .MAX_DELAY(MAXD)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_b.slave)
    );

    always #5 clk = ~clk;

    ent_t sb[$];
    int   gcyc = 0;
    int   tot_req = 0, vis_req = 0;
    int   tot_ack[2], vis_ack[2], tot_col[2], vis_col[2];
    logic exp_cons[2];
    int   exp_out[2];
    int   n_checks = 0;
    int   n_fail = 0;

    function automatic int model_eff(input int kind, input int d);
        int e;
        e = (d > MAXD) ? MAXD : d;
        if (kind == 1 && d == 0) e = 1;
        return e;
    endfunction

    function automatic int sat_inc(input int v, input int maxv);
        return (v >= maxv) ? maxv : v + 1;
    endfunction

    // One clock cycle: drive both DUTs at the falling edge, update the scoreboard, and leave
    // expected outputs for this cycle in exp_* and counter values visible now in vis_*.
    task automatic drive_cycle(input logic rst, input logic ant, input logic en, input int dly,
                               input logic inj, input logic fl);
        logic acc;
        bit   dup;
        int   fire;
        @(negedge clk);
        gcyc++;
        rst_n = rst;
        if_a.antecedent = ant; if_a.enable = en; if_a.delay = 4'(dly);
        if_a.inject_fail = inj; if_a.flush = fl;
        if_b.antecedent = ant; if_b.enable = en; if_b.delay = 4'(dly);
        if_b.inject_fail = inj; if_b.flush = fl;
        #2;
        vis_req = tot_req; vis_ack = tot_ack; vis_col = tot_col;
        if (!rst) begin
            sb.delete();
            tot_req = 0; tot_ack = '{0, 0}; tot_col = '{0, 0};
            vis_req = 0; vis_ack = '{0, 0}; vis_col = '{0, 0};
            exp_cons = '{1'b0, 1'b0}; exp_out = '{0, 0};
        end else begin
            acc = ant && en && !fl;
            if (acc) tot_req = sat_inc(tot_req, 65535);
            for (int k = 0; k < 2; k++) begin
                exp_out[k] = 0;
                foreach (sb[i])
                    if (sb[i].kind == k && sb[i].issue < gcyc && sb[i].fire >= gcyc) exp_out[k]++;
                if (acc && !inj) begin
                    fire = gcyc + model_eff(k, dly);
                    dup = 0;
                    foreach (sb[i]) if (sb[i].kind == k && sb[i].fire == fire) dup = 1;
                    if (dup) tot_col[k] = sat_inc(tot_col[k], 255);
                    else sb.push_back('{k, gcyc, fire});
                end
                exp_cons[k] = 1'b0;
                if (!fl) foreach (sb[i]) if (sb[i].kind == k && sb[i].fire == gcyc) exp_cons[k] = 1'b1;
                if (exp_cons[k]) tot_ack[k] = sat_inc(tot_ack[k], 65535);
            end
            for (int i = sb.size() - 1; i >= 0; i--)
                if (fl || sb[i].fire <= gcyc) sb.delete(i);
        end
    endtask

    task automatic reset_dut();
        drive_cycle(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        drive_cycle(1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        for (int c = 0; c < 3; c++) begin
            drive_cycle(1'b0, 1'b1, 1'b1, 0, 1'b0, 1'b0);
            n_checks += 4;
            if (if_a.consequent !== 1'b0) begin n_fail++; $display("FAIL reset cons_a c=%0d got=%b exp=0", c, if_a.consequent); end
            if (if_b.consequent !== 1'b0) begin n_fail++; $display("FAIL reset cons_b c=%0d got=%b exp=0", c, if_b.consequent); end
            if (if_a.outstanding !== 4'd0) begin n_fail++; $display("FAIL reset out_a c=%0d got=%0d exp=0", c, if_a.outstanding); end
            if (if_a.req_count !== 16'd0) begin n_fail++; $display("FAIL reset req_a c=%0d got=%0d exp=0", c, if_a.req_count); end
        end
        drive_cycle(1'b1, 1'b0, 1'b1, 0, 1'b0, 1'b0);
        n_checks += 3;
        if (if_a.req_count !== 16'd0) begin n_fail++; $display("FAIL reset req_after got=%0d exp=0", if_a.req_count); end
        if (if_a.ack_count !== 16'd0) begin n_fail++; $display("FAIL reset ack_after got=%0d exp=0", if_a.ack_count); end
        if (if_b.collision_count !== 8'd0) begin n_fail++; $display("FAIL reset col_after got=%0d exp=0", if_b.collision_count); end
    endtask

    task automatic test_latency();
        reset_dut();
        for (int c = 0; c < 16; c++) begin
            drive_cycle(1'b1, c == 5 || c == 10, 1'b1, (c == 10) ? 3 : 0, 1'b0, 1'b0);
            n_checks += 4;
            if (if_a.consequent !== exp_cons[0]) begin n_fail++; $display("FAIL latency cons_a c=%0d got=%b exp=%b", c, if_a.consequent, exp_cons[0]); end
            if (if_b.consequent !== exp_cons[1]) begin n_fail++; $display("FAIL latency cons_b c=%0d got=%b exp=%b", c, if_b.consequent, exp_cons[1]); end
            if (if_a.outstanding !== 4'(exp_out[0])) begin n_fail++; $display("FAIL latency out_a c=%0d got=%0d exp=%0d", c, if_a.outstanding, exp_out[0]); end
            if (if_b.outstanding !== 4'(exp_out[1])) begin n_fail++; $display("FAIL latency out_b c=%0d got=%0d exp=%0d", c, if_b.outstanding, exp_out[1]); end
            if (c == 5) begin
                n_checks += 2;
                if (if_a.consequent !== 1'b1) begin n_fail++; $display("FAIL latency overlap_d0 got=%b exp=1", if_a.consequent); end
                if (if_b.consequent !== 1'b0) begin n_fail++; $display("FAIL latency nonoverlap_d0_early got=%b exp=0", if_b.consequent); end
            end
            if (c == 6) begin
                n_checks += 3;
                if (if_b.consequent !== 1'b1) begin n_fail++; $display("FAIL latency nonoverlap_d0 got=%b exp=1", if_b.consequent); end
                if (if_a.req_count !== 16'd1) begin n_fail++; $display("FAIL latency req_a got=%0d exp=1", if_a.req_count); end
                if (if_a.ack_count !== 16'd1) begin n_fail++; $display("FAIL latency ack_a got=%0d exp=1", if_a.ack_count); end
            end
            if (c == 13) begin
                n_checks += 1;
                if (if_b.consequent !== 1'b1) begin n_fail++; $display("FAIL latency nonoverlap_d3 got=%b exp=1", if_b.consequent); end
            end
        end
    endtask

    task automatic test_collision();
        reset_dut();
        for (int c = 0; c < 8; c++) begin
            drive_cycle(1'b1, c == 0 || c == 2, 1'b1, (c == 0) ? 4 : 2, 1'b0, 1'b0);
            n_checks += 2;
            if (if_a.consequent !== exp_cons[0]) begin n_fail++; $display("FAIL collision cons_a c=%0d got=%b exp=%b", c, if_a.consequent, exp_cons[0]); end
            if (if_a.outstanding !== 4'(exp_out[0])) begin n_fail++; $display("FAIL collision out_a c=%0d got=%0d exp=%0d", c, if_a.outstanding, exp_out[0]); end
            if (c == 4) begin
                n_checks += 1;
                if (if_a.consequent !== 1'b1) begin n_fail++; $display("FAIL collision merged_pulse got=%b exp=1", if_a.consequent); end
            end
        end
        n_checks += 4;
        if (if_a.collision_count !== 8'd1) begin n_fail++; $display("FAIL collision col_a got=%0d exp=1", if_a.collision_count); end
        if (if_a.ack_count !== 16'd1) begin n_fail++; $display("FAIL collision ack_a got=%0d exp=1", if_a.ack_count); end
        if (if_a.req_count !== 16'd2) begin n_fail++; $display("FAIL collision req_a got=%0d exp=2", if_a.req_count); end
        if (if_b.collision_count !== 8'(vis_col[1])) begin n_fail++; $display("FAIL collision col_b got=%0d exp=%0d", if_b.collision_count, vis_col[1]); end
    endtask

    task automatic test_clamp();
        reset_dut();
        for (int c = 0; c < 10; c++) begin
            drive_cycle(1'b1, c == 0, 1'b1, 12, 1'b0, 1'b0);
            n_checks += 3;
            if (if_a.consequent !== exp_cons[0]) begin n_fail++; $display("FAIL clamp cons_a c=%0d got=%b exp=%b", c, if_a.consequent, exp_cons[0]); end
            if (if_a.outstanding !== ((c >= 1 && c <= 7) ? 4'd1 : 4'd0)) begin n_fail++; $display("FAIL clamp out_a c=%0d got=%0d", c, if_a.outstanding); end
            if (if_a.consequent !== (c == 7)) begin n_fail++; $display("FAIL clamp fire c=%0d got=%b exp=%b", c, if_a.consequent, c == 7); end
        end
    endtask

    task automatic test_flush();
        reset_dut();
        for (int c = 0; c < 11; c++) begin
            drive_cycle(1'b1, c <= 2, 1'b1, (c == 0) ? 5 : 6, 1'b0, c == 2);
            n_checks += 3;
            if (if_a.consequent !== 1'b0) begin n_fail++; $display("FAIL flush cons_a c=%0d got=%b exp=0", c, if_a.consequent); end
            if (if_a.outstanding !== 4'(exp_out[0])) begin n_fail++; $display("FAIL flush out_a c=%0d got=%0d exp=%0d", c, if_a.outstanding, exp_out[0]); end
            if (c >= 3 && if_b.outstanding !== 4'd0) begin n_fail++; $display("FAIL flush out_b c=%0d got=%0d exp=0", c, if_b.outstanding); end
        end
        n_checks += 1;
        if (if_a.req_count !== 16'd2) begin n_fail++; $display("FAIL flush req_a got=%0d exp=2", if_a.req_count); end
    endtask

    task automatic test_inject_reset();
        reset_dut();
        for (int c = 0; c < 14; c++) begin
            drive_cycle(c != 3, c <= 2, 1'b1, (c == 0) ? 2 : c + 4, c == 0, 1'b0);
            n_checks += 2;
            if (if_a.consequent !== 1'b0) begin n_fail++; $display("FAIL inject_reset cons_a c=%0d got=%b exp=0", c, if_a.consequent); end
            if (if_b.consequent !== 1'b0) begin n_fail++; $display("FAIL inject_reset cons_b c=%0d got=%b exp=0", c, if_b.consequent); end
            if (c == 1) begin
                n_checks += 2;
                if (if_a.req_count !== 16'd1) begin n_fail++; $display("FAIL inject_reset req_a got=%0d exp=1", if_a.req_count); end
                if (if_a.collision_count !== 8'd0) begin n_fail++; $display("FAIL inject_reset col_a got=%0d exp=0", if_a.collision_count); end
            end
            if (c == 2) begin
                n_checks += 2;
                if (if_a.ack_count !== 16'd0) begin n_fail++; $display("FAIL inject_reset ack_a got=%0d exp=0", if_a.ack_count); end
                if (if_a.outstanding !== 4'd1) begin n_fail++; $display("FAIL inject_reset out_pre got=%0d exp=1", if_a.outstanding); end
            end
            if (c == 3) begin
                n_checks += 3;
                if (if_a.outstanding !== 4'd0) begin n_fail++; $display("FAIL inject_reset out_rst got=%0d exp=0", if_a.outstanding); end
                if (if_a.req_count !== 16'd0) begin n_fail++; $display("FAIL inject_reset req_rst got=%0d exp=0", if_a.req_count); end
                if (if_b.outstanding !== 4'd0) begin n_fail++; $display("FAIL inject_reset out_b_rst got=%0d exp=0", if_b.outstanding); end
            end
        end
    endtask

    task automatic test_enable_drain();
        reset_dut();
        for (int c = 0; c < 8; c++) begin
            drive_cycle(1'b1, 1'b1, c == 0, (c == 0) ? 3 : 0, 1'b0, 1'b0);
            n_checks += 2;
            if (if_a.consequent !== (c == 3)) begin n_fail++; $display("FAIL enable_drain cons_a c=%0d got=%b exp=%b", c, if_a.consequent, c == 3); end
            if (if_a.req_count !== 16'(vis_req)) begin n_fail++; $display("FAIL enable_drain req_a c=%0d got=%0d exp=%0d", c, if_a.req_count, vis_req); end
        end
        n_checks += 1;
        if (if_a.req_count !== 16'd1) begin n_fail++; $display("FAIL enable_drain req_final got=%0d exp=1", if_a.req_count); end
    endtask

    task automatic test_back_to_back();
        reset_dut();
        for (int c = 0; c < 300; c++) begin
            drive_cycle(1'b1, 1'($urandom_range(0, 1)), $urandom_range(0, 7) != 0, int'($urandom_range(0, 15)),
                        $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0);
            n_checks += 8;
            if (if_a.consequent !== exp_cons[0]) begin n_fail++; $display("FAIL b2b cons_a c=%0d got=%b exp=%b", c, if_a.consequent, exp_cons[0]); end
            if (if_b.consequent !== exp_cons[1]) begin n_fail++; $display("FAIL b2b cons_b c=%0d got=%b exp=%b", c, if_b.consequent, exp_cons[1]); end
            if (if_a.outstanding !== 4'(exp_out[0])) begin n_fail++; $display("FAIL b2b out_a c=%0d got=%0d exp=%0d", c, if_a.outstanding, exp_out[0]); end
            if (if_b.outstanding !== 4'(exp_out[1])) begin n_fail++; $display("FAIL b2b out_b c=%0d got=%0d exp=%0d", c, if_b.outstanding, exp_out[1]); end
            if (if_a.req_count !== 16'(vis_req)) begin n_fail++; $display("FAIL b2b req_a c=%0d got=%0d exp=%0d", c, if_a.req_count, vis_req); end
            if (if_b.ack_count !== 16'(vis_ack[1])) begin n_fail++; $display("FAIL b2b ack_b c=%0d got=%0d exp=%0d", c, if_b.ack_count, vis_ack[1]); end
            if (if_a.collision_count !== 8'(vis_col[0])) begin n_fail++; $display("FAIL b2b col_a c=%0d got=%0d exp=%0d", c, if_a.collision_count, vis_col[0]); end
            if (if_b.collision_count !== 8'(vis_col[1])) begin n_fail++; $display("FAIL b2b col_b c=%0d got=%0d exp=%0d", c, if_b.collision_count, vis_col[1]); end
        end
    endtask

    task automatic test_saturation();
        reset_dut();
        for (int c = 0; c < 600; c++) begin
            drive_cycle(1'b1, 1'b1, 1'b1, (c % 2 == 0) ? 2 : 1, 1'b0, 1'b0);
            n_checks += 1;
            if (if_a.collision_count !== 8'(vis_col[0])) begin n_fail++; $display("FAIL saturation col_a c=%0d got=%0d exp=%0d", c, if_a.collision_count, vis_col[0]); end
        end
        drive_cycle(1'b1, 1'b0, 1'b1, 0, 1'b0, 1'b0);
        n_checks += 3;
        if (if_a.collision_count !== 8'hFF) begin n_fail++; $display("FAIL saturation col_a_final got=%0d exp=255", if_a.collision_count); end
        if (if_b.collision_count !== 8'hFF) begin n_fail++; $display("FAIL saturation col_b_final got=%0d exp=255", if_b.collision_count); end
        if (if_a.req_count !== 16'd600) begin n_fail++; $display("FAIL saturation req_a got=%0d exp=600", if_a.req_count); end
    endtask

    initial begin
        tot_ack = '{0, 0}; tot_col = '{0, 0}; vis_ack = '{0, 0}; vis_col = '{0, 0};
        if_a.antecedent = 1'b0; if_a.enable = 1'b0; if_a.delay = '0; if_a.inject_fail = 1'b0; if_a.flush = 1'b0;
        if_b.antecedent = 1'b0; if_b.enable = 1'b0; if_b.delay = '0; if_b.inject_fail = 1'b0; if_b.flush = 1'b0;
        test_reset();
        test_latency();
        test_collision();
        test_clamp();
        test_flush();
        test_inject_reset();
        test_enable_drain();
        test_back_to_back();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
